// File: rtl/vga_sprite_mux.sv
// Pipelined VGA pixel compositor: background window plus NSPR colour-keyed sprites.
// Shadow sprite attributes are committed at frame start; collisions are reported per frame.
module vga_sprite_mux #(
   parameter int unsigned NSPR = 4,
   parameter int unsigned IDXW = 2,
   parameter int unsigned SW   = 16,
   parameter int unsigned SH   = 16,
   parameter int unsigned BG_X = 1,
   parameter int unsigned BG_Y = 1,
   parameter int unsigned BG_W = 240,
   parameter int unsigned BG_H = 180,
   parameter int unsigned HBP  = 144,
   parameter int unsigned VBP  = 31,
   parameter logic [7:0]  KEY  = 8'h00
) (
   input  logic                 i_clk,
   input  logic                 i_clr,
   input  logic                 i_vidon,
   input  logic [9:0]           i_hc,
   input  logic [9:0]           i_vc,
   input  logic                 i_wr_en,
   input  logic [IDXW-1:0]      i_wr_idx,
   input  logic [10:0]          i_wr_x,
   input  logic [10:0]          i_wr_y,
   input  logic                 i_wr_vis,
   output logic [15:0]          o_bg_addr,
   input  logic [7:0]           i_bg_pix,
   output logic [16*NSPR-1:0]   o_spr_addr,
   input  logic [8*NSPR-1:0]    i_spr_pix,
   output logic [NSPR-1:0]      o_coll_mask,
   output logic                 o_frame_tick,
   output logic [2:0]           o_red,
   output logic [2:0]           o_green,
   output logic [1:0]           o_blue
);

   localparam int unsigned CW = 12;

   logic [10:0]        r_sh_x   [NSPR];
   logic [10:0]        r_sh_y   [NSPR];
   logic [NSPR-1:0]    r_sh_vis;
   logic [10:0]        r_act_x  [NSPR];
   logic [10:0]        r_act_y  [NSPR];
   logic [NSPR-1:0]    r_act_vis;

   logic [15:0]        r_bg_addr;
   logic [16*NSPR-1:0] r_spr_addr;
   logic               r_bg_in1;
   logic [NSPR-1:0]    r_hit1;
   logic               r_vid1;

   logic [7:0]         r_rgb;
   logic [NSPR-1:0]    r_coll_acc;
   logic [NSPR-1:0]    r_coll_mask;
   logic               r_frame_tick;

   logic               w_commit;
   logic [CW-1:0]      w_px;
   logic [CW-1:0]      w_py;
   logic               w_bg_in;
   logic [NSPR-1:0]    w_hit;
   logic [15:0]        w_bg_addr;
   logic [15:0]        w_spr_addr [NSPR];
   logic [NSPR-1:0]    w_opaque;
   logic [NSPR-1:0]    w_coll_new;
   logic [7:0]         w_colour;

   assign w_commit = (i_hc == 10'd0) && (i_vc == 10'd0);

   // Stage 0: window/sprite hit tests and ROM addresses (constant multiplies reduce to shift-add)
   always_comb begin
      w_px      = CW'(i_hc) - CW'(HBP);
      w_py      = CW'(i_vc) - CW'(VBP);
      w_bg_in   = (w_px >= CW'(BG_X)) && (w_px < CW'(BG_X + BG_W)) &&
                  (w_py >= CW'(BG_Y)) && (w_py < CW'(BG_Y + BG_H));
      w_bg_addr = 16'(w_py - CW'(BG_Y)) * 16'(BG_W) + 16'(w_px - CW'(BG_X));
      w_hit     = '0;
      for (int i = 0; i < NSPR; i++) begin
         w_hit[i] = r_act_vis[i] && w_bg_in &&
                    (w_px >= CW'(r_act_x[i])) && (w_px < CW'(r_act_x[i]) + CW'(SW)) &&
                    (w_py >= CW'(r_act_y[i])) && (w_py < CW'(r_act_y[i]) + CW'(SH));
         w_spr_addr[i] = 16'(w_py - CW'(r_act_y[i])) * 16'(SW) + 16'(w_px - CW'(r_act_x[i]));
      end
   end

   // Stage 1: transparency, priority (highest index wins) and collision detection
   always_comb begin
      w_opaque = '0;
      w_colour = r_bg_in1 ? i_bg_pix : 8'h00;
      for (int i = 0; i < NSPR; i++) begin
         w_opaque[i] = r_hit1[i] && (i_spr_pix[8*i +: 8] != KEY);
         if (w_opaque[i]) w_colour = i_spr_pix[8*i +: 8];
      end
      w_coll_new = ($countones(w_opaque) > 1) ? w_opaque : '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         for (int i = 0; i < NSPR; i++) begin
            r_sh_x[i]  <= '0;
            r_sh_y[i]  <= '0;
            r_act_x[i] <= '0;
            r_act_y[i] <= '0;
         end
         r_sh_vis     <= '0;
         r_act_vis    <= '0;
         r_bg_addr    <= '0;
         r_spr_addr   <= '0;
         r_bg_in1     <= 1'b0;
         r_hit1       <= '0;
         r_vid1       <= 1'b0;
         r_rgb        <= '0;
         r_coll_acc   <= '0;
         r_coll_mask  <= '0;
         r_frame_tick <= 1'b0;
      end else begin
         // A write coinciding with commit only reaches the shadow copy
         for (int i = 0; i < NSPR; i++) begin
            if (i_wr_en && (i_wr_idx == IDXW'(i))) begin
               r_sh_x[i]   <= i_wr_x;
               r_sh_y[i]   <= i_wr_y;
               r_sh_vis[i] <= i_wr_vis;
            end
            if (w_commit) begin
               r_act_x[i]   <= r_sh_x[i];
               r_act_y[i]   <= r_sh_y[i];
               r_act_vis[i] <= r_sh_vis[i];
            end
            r_spr_addr[16*i +: 16] <= w_hit[i] ? w_spr_addr[i] : 16'h0000;
         end
         r_frame_tick <= w_commit;

         r_bg_addr <= w_bg_in ? w_bg_addr : 16'h0000;
         r_bg_in1  <= w_bg_in;
         r_hit1    <= w_hit;
         r_vid1    <= i_vidon;

         r_rgb <= r_vid1 ? w_colour : 8'h00;

         if (w_commit) begin
            r_coll_mask <= r_coll_acc | w_coll_new;
            r_coll_acc  <= '0;
         end else begin
            r_coll_acc  <= r_coll_acc | w_coll_new;
         end
      end
   end

   assign o_bg_addr    = r_bg_addr;
   assign o_spr_addr   = r_spr_addr;
   assign o_coll_mask  = r_coll_mask;
   assign o_frame_tick = r_frame_tick;
   assign o_red        = r_rgb[7:5];
   assign o_green      = r_rgb[4:2];
   assign o_blue       = r_rgb[1:0];

endmodule

// File: tb/tb_vga_sprite_mux.sv
// Directed-vector bench for vga_sprite_mux with behavioural pixel ROMs.
module tb_vga_sprite_mux;

   localparam int unsigned NSPR = 4;
   localparam int unsigned IDXW = 2;
   localparam int unsigned HBP  = 144;
   localparam int unsigned VBP  = 31;

   localparam int OP_PIX = 0, OP_WR = 1, OP_COMMIT = 2, OP_KEY = 3, OP_CWR = 4;
   localparam int NV = 31;

   typedef struct {
      int          op;
      int          idx;
      int          x;
      int          y;
      logic        vid;
      logic [15:0] ebg;
      logic [15:0] esp;
      logic [7:0]  ergb;
      logic [3:0]  mask;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 clr;
   logic                 vidon;
   logic [9:0]           hc, vc;
   logic                 wr_en;
   logic [IDXW-1:0]      wr_idx;
   logic [10:0]          wr_x, wr_y;
   logic                 wr_vis;
   logic [15:0]          bg_addr;
   logic [7:0]           bg_pix;
   logic [16*NSPR-1:0]   spr_addr;
   logic [8*NSPR-1:0]    spr_pix;
   logic [NSPR-1:0]      coll_mask;
   logic                 frame_tick;
   logic [2:0]           red, green;
   logic [1:0]           blue;

   logic [7:0]           spr_col  [NSPR];
   logic [15:0]          key_addr [NSPR];
   vec_t                 v [NV];
   int                   total = 0;
   int                   bad   = 0;

   always #5 clk = ~clk;

   vga_sprite_mux dut (
      .i_clk(clk), .i_clr(clr), .i_vidon(vidon), .i_hc(hc), .i_vc(vc),
      .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_x(wr_x), .i_wr_y(wr_y), .i_wr_vis(wr_vis),
      .o_bg_addr(bg_addr), .i_bg_pix(bg_pix), .o_spr_addr(spr_addr), .i_spr_pix(spr_pix),
      .o_coll_mask(coll_mask), .o_frame_tick(frame_tick),
      .o_red(red), .o_green(green), .o_blue(blue)
   );

   // ROM data follows the registered address; background word 0 is 8'hE0, else low address byte
   always_comb begin
      bg_pix = (bg_addr == 16'h0000) ? 8'hE0 : bg_addr[7:0];
      for (int i = 0; i < NSPR; i++)
         spr_pix[8*i +: 8] = (spr_addr[16*i +: 16] == key_addr[i]) ? 8'h00 : spr_col[i];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      hc = 10'd1; vc = 10'd1; vidon = 1'b0; wr_en = 1'b0;
   endtask

   task automatic pix(input string nm, input int px, input int py, input logic vid,
                      input int ch, input logic [15:0] ebg, input logic [15:0] esp,
                      input logic [7:0] ergb);
      @(negedge clk);
      hc = 10'(px + HBP); vc = 10'(py + VBP); vidon = vid;
      @(posedge clk); #1;
      chk({nm, "_bg"}, 32'(bg_addr), 32'(ebg));
      chk({nm, "_sp"}, 32'(spr_addr[16*ch +: 16]), 32'(esp));
      idle();
      @(posedge clk); #1;
      chk({nm, "_rgb"}, 32'({red, green, blue}), 32'(ergb));
   endtask

   task automatic wr(input int idx, input int x, input int y, input logic vis);
      @(negedge clk);
      wr_en = 1'b1; wr_idx = IDXW'(idx); wr_x = 11'(x); wr_y = 11'(y); wr_vis = vis;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic commit(input string nm, input logic w, input int idx, input int x,
                         input int y, input logic vis, input logic [3:0] mask);
      @(negedge clk);
      hc = 10'd0; vc = 10'd0; vidon = 1'b0;
      if (w) begin
         wr_en = 1'b1; wr_idx = IDXW'(idx); wr_x = 11'(x); wr_y = 11'(y); wr_vis = vis;
      end
      @(posedge clk); #1;
      chk({nm, "_tick"}, 32'(frame_tick), 32'd1);
      chk({nm, "_coll"}, 32'(coll_mask), 32'(mask));
      idle();
      @(posedge clk); #1;
      chk({nm, "_tick_end"}, 32'(frame_tick), 32'd0);
   endtask

   initial begin
      spr_col[0] = 8'h03; spr_col[1] = 8'h1C; spr_col[2] = 8'hE3; spr_col[3] = 8'hFC;
      for (int i = 0; i < NSPR; i++) key_addr[i] = 16'hFFFF;

      //         op         idx  x    y   vid   ebg       esp       rgb    mask
      v[0]  = '{OP_PIX,    1,   1,   1,  1'b1, 16'h0000, 16'h0000, 8'hE0, 4'h0};
      v[1]  = '{OP_WR,     1,  50,  40,  1'b1, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[2]  = '{OP_PIX,    1,  50,  40,  1'b1, 16'h24C1, 16'h0000, 8'hC1, 4'h0};
      v[3]  = '{OP_COMMIT, 0,   0,   0,  1'b0, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[4]  = '{OP_PIX,    1,  50,  40,  1'b1, 16'h24C1, 16'h0000, 8'h1C, 4'h0};
      v[5]  = '{OP_PIX,    1,  65,  55,  1'b1, 16'h32E0, 16'h00FF, 8'h1C, 4'h0};
      v[6]  = '{OP_PIX,    1,  66,  55,  1'b1, 16'h32E1, 16'h0000, 8'hE1, 4'h0};
      v[7]  = '{OP_PIX,    1,  65,  55,  1'b0, 16'h32E0, 16'h00FF, 8'h00, 4'h0};
      v[8]  = '{OP_WR,     0,  55,  55,  1'b1, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[9]  = '{OP_WR,     3,  50,  50,  1'b1, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[10] = '{OP_COMMIT, 0,   0,   0,  1'b0, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[11] = '{OP_PIX,    3,  60,  60,  1'b1, 16'h378B, 16'h00AA, 8'hFC, 4'h0};
      v[12] = '{OP_PIX,    0,  60,  60,  1'b1, 16'h378B, 16'h0055, 8'hFC, 4'h0};
      v[13] = '{OP_COMMIT, 0,   0,   0,  1'b0, 16'h0000, 16'h0000, 8'h00, 4'h9};
      v[14] = '{OP_KEY,    3, 170,   0,  1'b0, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[15] = '{OP_PIX,    3,  60,  60,  1'b1, 16'h378B, 16'h00AA, 8'h03, 4'h0};
      v[16] = '{OP_COMMIT, 0,   0,   0,  1'b0, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[17] = '{OP_KEY,    3, 65535, 0,  1'b0, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[18] = '{OP_WR,     2, 100, 100,  1'b1, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[19] = '{OP_WR,     2, 120, 100,  1'b1, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[20] = '{OP_COMMIT, 0,   0,   0,  1'b0, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[21] = '{OP_PIX,    2, 100, 100,  1'b1, 16'h5D33, 16'h0000, 8'h33, 4'h0};
      v[22] = '{OP_PIX,    2, 120, 100,  1'b1, 16'h5D47, 16'h0000, 8'hE3, 4'h0};
      v[23] = '{OP_CWR,    2, 230, 100,  1'b1, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[24] = '{OP_PIX,    2, 240, 100,  1'b1, 16'h5DBF, 16'h0000, 8'hBF, 4'h0};
      v[25] = '{OP_COMMIT, 0,   0,   0,  1'b0, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[26] = '{OP_PIX,    2, 240, 100,  1'b1, 16'h5DBF, 16'h000A, 8'hE3, 4'h0};
      v[27] = '{OP_PIX,    2, 241, 100,  1'b1, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[28] = '{OP_PIX,    2, 240, 180,  1'b1, 16'hA8BF, 16'h0000, 8'hBF, 4'h0};
      v[29] = '{OP_PIX,    2, 240, 181,  1'b1, 16'h0000, 16'h0000, 8'h00, 4'h0};
      v[30] = '{OP_PIX,    2,   0,   1,  1'b1, 16'h0000, 16'h0000, 8'h00, 4'h0};

      idle();
      wr_idx = '0; wr_x = '0; wr_y = '0; wr_vis = 1'b0;
      clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rgb",  32'({red, green, blue}), 32'd0);
      chk("rst_coll", 32'(coll_mask), 32'd0);
      chk("rst_tick", 32'(frame_tick), 32'd0);
      chk("rst_bg",   32'(bg_addr), 32'd0);
      chk("rst_sp",   spr_addr[31:0], 32'd0);
      @(negedge clk);
      clr = 1'b0;

      for (int i = 0; i < NV; i++) begin
         case (v[i].op)
            OP_PIX:    pix($sformatf("v%0d", i), v[i].x, v[i].y, v[i].vid,
                           v[i].idx, v[i].ebg, v[i].esp, v[i].ergb);
            OP_WR:     wr(v[i].idx, v[i].x, v[i].y, v[i].vid);
            OP_COMMIT: commit($sformatf("v%0d", i), 1'b0, 0, 0, 0, 1'b0, v[i].mask);
            OP_CWR:    commit($sformatf("v%0d", i), 1'b1, v[i].idx, v[i].x, v[i].y,
                              v[i].vid, v[i].mask);
            OP_KEY:    key_addr[v[i].idx] = 16'(v[i].x);
            default:   ;
         endcase
      end

      // Reset in the middle of a visible sprite pixel blanks the next output
      @(negedge clk);
      hc = 10'(240 + HBP); vc = 10'(100 + VBP); vidon = 1'b1;
      @(posedge clk); #1;
      chk("clr_pre_sp", 32'(spr_addr[47:32]), 32'h000A);
      idle();
      clr = 1'b1;
      @(posedge clk); #1;
      chk("clr_rgb",  32'({red, green, blue}), 32'd0);
      chk("clr_sp",   32'(spr_addr[47:32]), 32'd0);
      chk("clr_coll", 32'(coll_mask), 32'd0);
      @(negedge clk);
      clr = 1'b0;
      pix("post_clr", 240, 100, 1'b1, 2, 16'h5DBF, 16'h0000, 8'hBF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
